// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the program counter, walks IDLE -> RUN -> DONE,
// and counts retired instructions for a combinational InstROM.
module inst_fetch_ctrl #(
  parameter int            A          = 10,
  parameter logic [A-1:0]  START_ADDR = '0,
  parameter int            CW         = 16
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic          Stall,
  input  logic          Halt,
  input  logic          JumpEn,
  input  logic [A-1:0]  JumpTarget,
  input  logic          BranchEn,
  input  logic [A-1:0]  BranchOffset,
  output logic [A-1:0]  InstAddress,
  output logic          InstValid,
  output logic          Done,
  output logic [CW-1:0] InstCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_p0;
  logic [A-1:0]    pc_p0;
  logic [CW-1:0]   cnt_p0;
  logic            vld_p0;
  logic            done_p0;
  logic signed [A-1:0] br_off;

  assign br_off = BranchOffset;

  // Retired-instruction counter sticks at all-ones instead of rolling over.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + CW'(1);
  endfunction

  // PC arithmetic is deliberately A bits wide so jumps and branches wrap silently.
  function automatic logic [A-1:0] next_pc(input logic [A-1:0]        pc,
                                           input logic                jmp,
                                           input logic [A-1:0]        tgt,
                                           input logic                br,
                                           input logic signed [A-1:0] off);
    if (jmp)     return tgt;
    else if (br) return pc + $unsigned(off);
    else         return pc + A'(1);
  endfunction

  // Stage p0: state, PC, counter and the status flags all update together.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_p0 <= IDLE;
      pc_p0    <= START_ADDR;
      cnt_p0   <= '0;
      vld_p0   <= 1'b0;
      done_p0  <= 1'b0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (Start) begin
            state_p0 <= RUN;
            pc_p0    <= START_ADDR;
            cnt_p0   <= '0;
            vld_p0   <= 1'b1;
          end
        end
        RUN: begin
          if (!Stall) begin
            cnt_p0 <= sat_inc(cnt_p0);
            if (Halt) begin
              state_p0 <= DONE;
              vld_p0   <= 1'b0;
              done_p0  <= 1'b1;
            end else begin
              pc_p0 <= next_pc(pc_p0, JumpEn, JumpTarget, BranchEn, br_off);
            end
          end
        end
        DONE: begin
          if (Start) begin
            state_p0 <= RUN;
            pc_p0    <= START_ADDR;
            cnt_p0   <= '0;
            vld_p0   <= 1'b1;
            done_p0  <= 1'b0;
          end
        end
        default: begin
          state_p0 <= IDLE;
          vld_p0   <= 1'b0;
          done_p0  <= 1'b0;
        end
      endcase
    end
  end

  assign InstAddress = pc_p0;
  assign InstValid   = vld_p0;
  assign Done        = done_p0;
  assign InstCount   = cnt_p0;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: vector table plus hand sequences for halt,
// asynchronous reset, and a narrow instance for counter saturation and PC wrap.
module tb_inst_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Start, Stall, Halt, JumpEn, BranchEn;
  logic [9:0]  JumpTarget, BranchOffset;
  logic [9:0]  InstAddress;
  logic        InstValid, Done;
  logic [15:0] InstCount;

  logic        r2_n, s2_start;
  logic [3:0]  a2;
  logic        v2, d2;
  logic [2:0]  c2;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  inst_fetch_ctrl #(.A(10), .START_ADDR(10'd0), .CW(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall), .Halt(Halt),
    .JumpEn(JumpEn), .JumpTarget(JumpTarget), .BranchEn(BranchEn),
    .BranchOffset(BranchOffset), .InstAddress(InstAddress), .InstValid(InstValid),
    .Done(Done), .InstCount(InstCount)
  );

  inst_fetch_ctrl #(.A(4), .START_ADDR(4'd14), .CW(3)) dut_small (
    .Clk(Clk), .Reset_n(r2_n), .Start(s2_start), .Stall(1'b0), .Halt(1'b0),
    .JumpEn(1'b0), .JumpTarget(4'd0), .BranchEn(1'b0), .BranchOffset(4'd0),
    .InstAddress(a2), .InstValid(v2), .Done(d2), .InstCount(c2)
  );

  // Combinational instruction ROM model with a distinct word per address.
  logic [15:0] rom [1024];
  logic [15:0] rom_data;
  initial for (int i = 0; i < 1024; i++) rom[i] = 16'(i * 37) ^ 16'hA5A5;
  assign rom_data = rom[InstAddress];

  typedef struct {
    logic        start, stall, halt, jen;
    logic [9:0]  jt;
    logic        ben;
    logic [9:0]  boff;
    logic [9:0]  ea;
    logic        ev, ed;
    logic [15:0] ec;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic sl, input logic h,
                              input logic je, input logic [9:0] jt,
                              input logic be, input logic [9:0] bo,
                              input logic [9:0] ea, input logic ev,
                              input logic ed, input logic [15:0] ec);
    vec_t v;
    v.start = st; v.stall = sl; v.halt = h; v.jen = je; v.jt = jt;
    v.ben = be; v.boff = bo; v.ea = ea; v.ev = ev; v.ed = ed; v.ec = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [9:0] ea, input logic ev,
                            input logic ed, input logic [15:0] ec);
    check({tag, ".addr"},  32'(InstAddress), 32'(ea));
    check({tag, ".valid"}, 32'(InstValid),   32'(ev));
    check({tag, ".done"},  32'(Done),        32'(ed));
    check({tag, ".count"}, 32'(InstCount),   32'(ec));
    if (ev) check({tag, ".rom"}, 32'(rom_data), 32'(rom[ea]));
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge Clk);
    Start = v.start; Stall = v.stall; Halt = v.halt; JumpEn = v.jen;
    JumpTarget = v.jt; BranchEn = v.ben; BranchOffset = v.boff;
    @(posedge Clk);
    #1;
    check_outs(tag, v.ea, v.ev, v.ed, v.ec);
  endtask

  task automatic idle_inputs();
    Start = 0; Stall = 0; Halt = 0; JumpEn = 0; BranchEn = 0;
    JumpTarget = '0; BranchOffset = '0;
  endtask

  vec_t tbl [21];
  vec_t nop;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    Reset_n = 1'b0;
    r2_n = 1'b0;
    s2_start = 1'b0;
    nop = mk(0,0,0, 0,10'd0, 0,10'd0, 10'd0,0,0,16'd0);

    //                 st sl h  je jt       be boff     ea       ev ed cnt
    tbl[0]  = mk(0, 0, 0, 0, 10'd0,   0, 10'd0,   10'd0,   0, 0, 16'd0);
    tbl[1]  = mk(1, 0, 0, 0, 10'd0,   0, 10'd0,   10'd0,   1, 0, 16'd0);
    tbl[2]  = mk(0, 0, 0, 0, 10'd0,   0, 10'd0,   10'd1,   1, 0, 16'd1);
    tbl[3]  = mk(0, 0, 0, 0, 10'd0,   0, 10'd0,   10'd2,   1, 0, 16'd2);
    tbl[4]  = mk(0, 0, 0, 0, 10'd0,   0, 10'd0,   10'd3,   1, 0, 16'd3);
    tbl[5]  = mk(1, 1, 1, 1, 10'd9,   1, 10'd5,   10'd3,   1, 0, 16'd3);
    tbl[6]  = mk(0, 1, 0, 0, 10'd0,   1, 10'd5,   10'd3,   1, 0, 16'd3);
    tbl[7]  = mk(0, 0, 0, 0, 10'd0,   0, 10'd0,   10'd4,   1, 0, 16'd4);
    tbl[8]  = mk(0, 0, 0, 0, 10'd0,   0, 10'd0,   10'd5,   1, 0, 16'd5);
    tbl[9]  = mk(0, 0, 0, 0, 10'd0,   1, 10'h3FE, 10'd3,   1, 0, 16'd6);
    tbl[10] = mk(1, 0, 0, 0, 10'd0,   0, 10'd0,   10'd4,   1, 0, 16'd7);
    tbl[11] = mk(0, 0, 0, 0, 10'd0,   1, 10'h3FE, 10'd2,   1, 0, 16'd8);
    tbl[12] = mk(0, 0, 0, 1, 10'h3FF, 1, 10'd5,   10'h3FF, 1, 0, 16'd9);
    tbl[13] = mk(0, 0, 0, 0, 10'd0,   0, 10'd0,   10'd0,   1, 0, 16'd10);
    tbl[14] = mk(0, 0, 0, 0, 10'd0,   1, 10'h3FF, 10'h3FF, 1, 0, 16'd11);
    tbl[15] = mk(0, 0, 0, 0, 10'd0,   1, 10'd3,   10'd2,   1, 0, 16'd12);
    tbl[16] = mk(0, 0, 0, 1, 10'd7,   0, 10'd0,   10'd7,   1, 0, 16'd13);
    tbl[17] = mk(0, 0, 1, 1, 10'd20,  1, 10'd1,   10'd7,   0, 1, 16'd14);
    tbl[18] = mk(0, 0, 0, 1, 10'd30,  1, 10'd1,   10'd7,   0, 1, 16'd14);
    tbl[19] = mk(1, 0, 0, 0, 10'd0,   0, 10'd0,   10'd0,   1, 0, 16'd0);
    tbl[20] = mk(0, 0, 0, 0, 10'd0,   0, 10'd0,   10'd1,   1, 0, 16'd1);

    #1;
    check_outs("reset", 10'd0, 0, 0, 16'd0);
    @(negedge Clk);
    Reset_n = 1'b1;

    for (int i = 0; i < 21; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Halt at PC 7 retires the halt instruction, then restart from DONE.
    @(negedge Clk); idle_inputs(); Reset_n = 1'b0;
    @(negedge Clk); Reset_n = 1'b1;
    apply(mk(1,0,0, 0,10'd0, 0,10'd0, 10'd0,1,0,16'd0), "halt_start");
    for (int k = 1; k <= 7; k++)
      apply(mk(0,0,0, 0,10'd0, 0,10'd0, 10'(k),1,0,16'(k)), $sformatf("halt_run%0d", k));
    apply(mk(0,0,1, 0,10'd0, 0,10'd0, 10'd7,0,1,16'd8), "halt_done");
    apply(mk(1,0,0, 0,10'd0, 0,10'd0, 10'd0,1,0,16'd0), "halt_restart");

    // Reset dropped between edges at PC 6 takes effect without a clock.
    for (int k = 1; k <= 6; k++)
      apply(mk(0,0,0, 0,10'd0, 0,10'd0, 10'(k),1,0,16'(k)), $sformatf("ar_run%0d", k));
    @(negedge Clk);
    idle_inputs();
    #2 Reset_n = 1'b0;
    #1 check_outs("async_rst", 10'd0, 0, 0, 16'd0);
    Start = 1'b1;
    repeat (2) @(posedge Clk);
    #1 check_outs("rst_held_start", 10'd0, 0, 0, 16'd0);
    @(negedge Clk);
    Start = 1'b0;
    Reset_n = 1'b1;
    @(posedge Clk);
    #1 check_outs("rst_release_idle", 10'd0, 0, 0, 16'd0);
    apply(mk(1,0,0, 0,10'd0, 0,10'd0, 10'd0,1,0,16'd0), "post_rst_start");
    apply(mk(0,0,0, 0,10'd0, 0,10'd0, 10'd1,1,0,16'd1), "post_rst_run");

    // Narrow instance: non-zero entry address, PC wrap 15->0, counter saturation.
    @(negedge Clk); idle_inputs(); r2_n = 1'b1; s2_start = 1'b1;
    @(posedge Clk); #1;
    check("small.addr0", 32'(a2), 32'd14);
    check("small.valid0", 32'(v2), 32'd1);
    check("small.count0", 32'(c2), 32'd0);
    @(negedge Clk); s2_start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge Clk); #1;
      check($sformatf("small.addr%0d", k),  32'(a2), 32'((14 + k) % 16));
      check($sformatf("small.count%0d", k), 32'(c2), 32'((k > 7) ? 7 : k));
    end
    check("small.done", 32'(d2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 The block SHALL expose parameter A, default 10, meaning instruction address width.
REQ-002 The block SHALL expose parameter START_ADDR, default 0, meaning the A-bit program entry address.
REQ-003 The block SHALL expose parameter CW, default 16, meaning issued-instruction counter width.
REQ-004 Clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 Start  input  1  begin program execution; sampled only in IDLE or DONE.
REQ-007 Stall  input  1  hold PC and counter this cycle.
REQ-008 Halt  input  1  decoded halt instruction at current InstAddress.
REQ-009 JumpEn  input  1  absolute jump request.
REQ-010 JumpTarget  input  A  absolute jump target.
REQ-011 BranchEn  input  1  relative branch request.
REQ-012 BranchOffset  input  A  two's-complement offset, added to current PC.
REQ-013 InstAddress  output  A  address driven to InstROM (registered PC).
REQ-014 InstValid  output  1  InstAddress holds a live fetch this cycle.
REQ-015 Done  output  1  program finished; high in DONE only.
REQ-016 InstCount  output  CW  count of instructions retired since last Start.

Function
REQ-017 The block SHALL implement states IDLE, RUN, DONE, held in a state register.
REQ-018 IDLE: InstValid=0, PC=START_ADDR; Start=1 -> RUN next cycle, InstCount cleared to 0.
REQ-019 RUN: InstValid SHALL be 1 combinationally from state; InstAddress equals PC with zero added latency (InstROM is combinational).
REQ-020 In RUN with Stall=1, PC, InstCount and state SHALL hold; Halt, JumpEn, BranchEn SHALL be ignored that cycle.
REQ-021 In RUN with Stall=0, next-PC priority SHALL be: Halt (PC holds, state -> DONE) > JumpEn (PC=JumpTarget) > BranchEn (PC=PC+BranchOffset) > PC+1.
REQ-022 All PC arithmetic SHALL be modulo 2^A; PC=2^A-1 incrementing SHALL wrap to 0; branch overflow/underflow SHALL wrap silently.
REQ-023 In RUN with Stall=0, InstCount SHALL increment by 1 per cycle, including the Halt cycle, saturating at 2^CW-1.
REQ-024 DONE: Done=1, InstValid=0, PC and InstCount SHALL hold final values; Start=1 -> RUN with PC=START_ADDR, InstCount=0.
REQ-025 Start asserted while in RUN SHALL have no effect.
REQ-026 Simultaneous JumpEn and BranchEn SHALL take JumpTarget; simultaneous Halt with either SHALL halt without redirect.
REQ-027 All outputs SHALL be derived from registered state with no combinational path from inputs to outputs.

Reset
REQ-028 Reset_n=0 SHALL immediately, without waiting for Clk, force state=IDLE, PC=START_ADDR, InstCount=0, InstValid=0, Done=0.
REQ-029 Reset asserted mid-RUN or in DONE SHALL abandon execution; after release the block SHALL remain in IDLE until Start.
REQ-030 Release of Reset_n SHALL take effect at the first rising Clk edge with Reset_n=1; no input SHALL be sampled before it.

Verification
REQ-031 Reset, Start pulse, no redirects for 5 cycles -> InstAddress 0,1,2,3,4 with InstValid=1, InstCount=5.
REQ-032 In RUN at PC=3, Stall=1 for 2 cycles -> InstAddress stays 3, InstCount unchanged; release -> PC 4.
REQ-033 At PC=5, BranchOffset=10'h3FE (-2) -> PC 3; at PC=2, JumpEn with JumpTarget=10'h3FF and BranchEn both high -> PC 1023, next PC 0 (wrap).
REQ-034 At PC=7, Halt=1 -> next cycle Done=1, InstValid=0, InstAddress=7, InstCount=8; Start -> PC 0, InstCount 0, Done 0.
REQ-035 Reset_n pulled low between clock edges in RUN at PC=6 -> outputs reset immediately (InstAddress 0, InstValid 0) before next edge; Start ignored until Reset_n released.
REQ-036 Each fetch cycle, bench SHALL compare InstROM output at InstAddress against machinecode file contents loaded by $readmemb.
